// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared types and default sizing for the FIR sample scheduler
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ERR   = 2'd3
    } sched_state_t;

    localparam int SCHED_IN_DEPTH       = 8;
    localparam int SCHED_OUT_DEPTH      = 8;
    localparam int SCHED_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/fir_sync_fifo.sv
// rtl/fir_sync_fifo.sv - first-word fall-through synchronous FIFO with occupancy count
module fir_sync_fifo
    import fir_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A full FIFO refuses a push even when a pop happens in the same cycle.
    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fir_sample_scheduler.sv
// rtl/fir_sample_scheduler.sv - buffers samples into the FIR datapath one at a time and queues results
module fir_sample_scheduler
    import fir_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int IN_DEPTH       = SCHED_IN_DEPTH,
    parameter int OUT_DEPTH      = SCHED_OUT_DEPTH,
    parameter int TIMEOUT_CYCLES = SCHED_TIMEOUT_CYCLES
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    input  logic                         dp_ready,
    output logic                         dp_x_valid,
    output logic [DATA_W-1:0]            dp_x_data,
    input  logic                         dp_y_valid,
    input  logic [DATA_W-1:0]            dp_y_data,
    output logic                         busy,
    output logic                         timeout_err,
    output logic [$clog2(IN_DEPTH):0]    in_count,
    output logic [$clog2(OUT_DEPTH):0]   out_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    sched_state_t      state;
    sched_state_t      state_next;
    logic [TW-1:0]     timer;
    logic              in_full;
    logic              in_empty;
    logic              out_full;
    logic              out_empty;
    logic              in_push;
    logic              in_pop;
    logic              out_push;
    logic              out_pop;
    logic [DATA_W-1:0] in_head;
    logic [DATA_W-1:0] out_head;

    assign in_ready = !in_full && !rst;
    assign in_push  = in_valid && in_ready;
    assign out_pop  = out_valid && out_ready;

    fir_sync_fifo #(.WIDTH(DATA_W), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_push),
        .pop   (in_pop),
        .flush (flush),
        .din   (in_data),
        .full  (in_full),
        .empty (in_empty),
        .count (in_count),
        .head  (in_head)
    );

    fir_sync_fifo #(.WIDTH(DATA_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (out_push),
        .pop   (out_pop),
        .flush (flush),
        .din   (dp_y_data),
        .full  (out_full),
        .empty (out_empty),
        .count (out_count),
        .head  (out_head)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst || state == ISSUE) timer <= '0;
        else if (state == WAIT)    timer <= timer + 1'b1;
    end

    // Issuing only when an output slot is free guarantees the result always has a home.
    always_comb begin
        state_next = state;
        in_pop     = 1'b0;
        out_push   = 1'b0;
        case (state)
            IDLE: begin
                if (enable && dp_ready && !in_empty && !out_full) state_next = ISSUE;
            end
            ISSUE: begin
                in_pop     = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (dp_y_valid) begin
                    out_push   = 1'b1;
                    state_next = IDLE;
                end else if (timer == TIMER_LAST) begin
                    state_next = ERR;
                end
            end
            ERR:     state_next = ERR;
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    assign dp_x_valid  = (state == ISSUE);
    assign dp_x_data   = dp_x_valid ? in_head : '0;
    assign busy        = (state == ISSUE) || (state == WAIT);
    assign timeout_err = (state == ERR);
    assign out_valid   = !out_empty;
    assign out_data    = out_empty ? '0 : out_head;

endmodule

// File: tb/tb_fir_sample_scheduler.sv
// tb/tb_fir_sample_scheduler.sv - directed self-checking bench for fir_sample_scheduler
module tb_fir_sample_scheduler;

    localparam int DP_LAT = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        dp_ready;
    logic        dp_x_valid;
    logic [31:0] dp_x_data;
    logic        dp_y_valid;
    logic [31:0] dp_y_data;
    logic        busy;
    logic        timeout_err;
    logic [3:0]  in_count;
    logic [3:0]  out_count;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic        dp_auto;
    logic        force_y;
    logic [31:0] force_data;
    int          dp_cnt;
    logic [31:0] dp_held;
    int          x_cyc[$];
    logic [31:0] x_dat[$];

    fir_sample_scheduler #(
        .DATA_W(32), .IN_DEPTH(8), .OUT_DEPTH(8), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .dp_ready(dp_ready), .dp_x_valid(dp_x_valid), .dp_x_data(dp_x_data),
        .dp_y_valid(dp_y_valid), .dp_y_data(dp_y_data),
        .busy(busy), .timeout_err(timeout_err),
        .in_count(in_count), .out_count(out_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Datapath model: answers x+1 DP_LAT cycles after the strobe; also logs every strobe.
    initial begin
        dp_y_valid = 1'b0;
        dp_y_data  = '0;
        dp_cnt     = 0;
        dp_held    = '0;
        forever begin
            @(negedge clk);
            #2;
            dp_y_valid = 1'b0;
            if (dp_auto && dp_cnt > 0) begin
                dp_cnt--;
                if (dp_cnt == 0) begin
                    dp_y_valid = 1'b1;
                    dp_y_data  = dp_held + 32'd1;
                end
            end
            if (force_y) begin
                dp_y_valid = 1'b1;
                dp_y_data  = force_data;
            end
            if (dp_x_valid) begin
                x_cyc.push_back(cyc);
                x_dat.push_back(dp_x_data);
                if (dp_auto) begin
                    dp_cnt  = DP_LAT;
                    dp_held = dp_x_data;
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (dp_x_valid !== 1'b0) $display("FAIL reset_dp_x_valid: got %b want 0", dp_x_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (timeout_err !== 1'b0) $display("FAIL reset_timeout_err: got %b want 0", timeout_err); else n_pass++;
        n_checks++; if (in_count !== 4'd0) $display("FAIL reset_in_count: got %0d want 0", in_count); else n_pass++;
        n_checks++; if (out_count !== 4'd0) $display("FAIL reset_out_count: got %0d want 0", out_count); else n_pass++;
        n_checks++; if (out_data !== 32'd0) $display("FAIL reset_out_data: got %h want 0", out_data); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_stream();
        logic [31:0] vals [3];
        logic [31:0] res[$];
        int base, pushed, c0, n;
        vals = '{32'h10, 32'h20, 32'h30};
        enable = 1'b1; dp_ready = 1'b1; dp_auto = 1'b1; out_ready = 1'b1;
        base = x_cyc.size(); pushed = 0; c0 = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (out_valid) res.push_back(out_data);
            if (pushed < 3 && in_ready) begin
                in_valid = 1'b1; in_data = vals[pushed];
                if (pushed == 0) c0 = cyc;
                pushed++;
            end else begin
                in_valid = 1'b0;
            end
        end
        n = x_cyc.size() - base;
        n_checks++; if (n !== 3) $display("FAIL stream_issue_count: got %0d want 3", n); else n_pass++;
        n_checks++; if (res.size() !== 3) $display("FAIL stream_result_count: got %0d want 3", res.size()); else n_pass++;
        if (n >= 3) begin
            n_checks++; if (x_cyc[base] !== c0 + 2) $display("FAIL stream_first_latency: got %0d want %0d", x_cyc[base] - c0, 2); else n_pass++;
            for (int i = 1; i < 3; i++) begin
                n_checks++; if (x_cyc[base+i] - x_cyc[base+i-1] !== 8) $display("FAIL stream_spacing[%0d]: got %0d want 8", i, x_cyc[base+i] - x_cyc[base+i-1]); else n_pass++;
            end
            for (int i = 0; i < 3; i++) begin
                n_checks++; if (x_dat[base+i] !== vals[i]) $display("FAIL stream_x_data[%0d]: got %h want %h", i, x_dat[base+i], vals[i]); else n_pass++;
            end
        end
        if (res.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                n_checks++; if (res[i] !== vals[i] + 32'd1) $display("FAIL stream_out_data[%0d]: got %h want %h", i, res[i], vals[i] + 32'd1); else n_pass++;
            end
        end
    endtask

    task automatic test_in_backpressure();
        logic [31:0] res[$];
        int base, n;
        dp_ready = 1'b0; out_ready = 1'b1; dp_auto = 1'b1;
        base = x_cyc.size();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 32'h100 + 32'(i);
        end
        @(negedge clk);
        in_data = 32'h1FF;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_ninth_in_ready: got %b want 0", in_ready); else n_pass++;
        n_checks++; if (in_count !== 4'd8) $display("FAIL bp_in_count: got %0d want 8", in_count); else n_pass++;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (in_count !== 4'd8) $display("FAIL bp_in_count_hold: got %0d want 8", in_count); else n_pass++;
        n_checks++; if (x_cyc.size() - base !== 0) $display("FAIL bp_no_issue: got %0d want 0", x_cyc.size() - base); else n_pass++;
        dp_ready = 1'b1;
        for (int k = 0; k < 90; k++) begin
            @(negedge clk);
            if (out_valid) res.push_back(out_data);
        end
        n = x_cyc.size() - base;
        n_checks++; if (n !== 8) $display("FAIL bp_issue_count: got %0d want 8", n); else n_pass++;
        n_checks++; if (res.size() !== 8) $display("FAIL bp_result_count: got %0d want 8", res.size()); else n_pass++;
        if (n >= 8 && res.size() >= 8) begin
            for (int i = 0; i < 8; i++) begin
                n_checks++; if (x_dat[base+i] !== 32'h100 + 32'(i)) $display("FAIL bp_x_data[%0d]: got %h want %h", i, x_dat[base+i], 32'h100 + 32'(i)); else n_pass++;
                n_checks++; if (res[i] !== 32'h101 + 32'(i)) $display("FAIL bp_out_data[%0d]: got %h want %h", i, res[i], 32'h101 + 32'(i)); else n_pass++;
            end
        end
    endtask

    task automatic test_out_full();
        int base, pushed, n;
        out_ready = 1'b0; dp_ready = 1'b1; dp_auto = 1'b1;
        base = x_cyc.size(); pushed = 0;
        for (int k = 0; k < 110; k++) begin
            @(negedge clk);
            if (pushed < 10 && in_ready) begin
                in_valid = 1'b1; in_data = 32'h200 + 32'(pushed); pushed++;
            end else begin
                in_valid = 1'b0;
            end
        end
        n = x_cyc.size() - base;
        n_checks++; if (n !== 8) $display("FAIL full_issue_count: got %0d want 8", n); else n_pass++;
        n_checks++; if (out_count !== 4'd8) $display("FAIL full_out_count: got %0d want 8", out_count); else n_pass++;
        n_checks++; if (in_count !== 4'd2) $display("FAIL full_in_count: got %0d want 2", in_count); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL full_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (out_data !== 32'h201) $display("FAIL full_head: got %h want 201", out_data); else n_pass++;
        @(negedge clk); out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
        for (int k = 0; k < 20; k++) @(negedge clk);
        n = x_cyc.size() - base;
        n_checks++; if (n !== 9) $display("FAIL full_issue_after_pop: got %0d want 9", n); else n_pass++;
        if (n >= 9) begin
            n_checks++; if (x_dat[base+8] !== 32'h208) $display("FAIL full_ninth_data: got %h want 208", x_dat[base+8]); else n_pass++;
        end
        n_checks++; if (out_count !== 4'd8) $display("FAIL full_out_count_refill: got %0d want 8", out_count); else n_pass++;
        n_checks++; if (in_count !== 4'd1) $display("FAIL full_in_count_after: got %0d want 1", in_count); else n_pass++;
        flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        n_checks++; if (in_count !== 4'd0 || out_count !== 4'd0) $display("FAIL full_flush_counts: got %0d/%0d want 0/0", in_count, out_count); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL full_flush_out_valid: got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_timeout();
        int base, pushed, i_cyc, err_cyc;
        dp_auto = 1'b0; out_ready = 1'b1; dp_ready = 1'b1;
        base = x_cyc.size(); pushed = 0; i_cyc = -1; err_cyc = -1;
        for (int k = 0; k < 90; k++) begin
            @(negedge clk);
            if (dp_x_valid && i_cyc < 0) i_cyc = cyc;
            if (timeout_err && err_cyc < 0) err_cyc = cyc;
            if (pushed < 2 && in_ready) begin
                in_valid = 1'b1; in_data = 32'h300 + 32'(pushed); pushed++;
            end else begin
                in_valid = 1'b0;
            end
        end
        n_checks++; if (i_cyc < 0 || err_cyc !== i_cyc + 65) $display("FAIL to_err_latency: got %0d want %0d", err_cyc - i_cyc, 65); else n_pass++;
        n_checks++; if (x_cyc.size() - base !== 1) $display("FAIL to_no_reissue: got %0d want 1", x_cyc.size() - base); else n_pass++;
        n_checks++; if (in_count !== 4'd1) $display("FAIL to_in_count: got %0d want 1", in_count); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL to_busy: got %b want 0", busy); else n_pass++;
        flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        n_checks++; if (timeout_err !== 1'b0) $display("FAIL to_flush_err: got %b want 0", timeout_err); else n_pass++;
        n_checks++; if (in_count !== 4'd0 || out_count !== 4'd0) $display("FAIL to_flush_counts: got %0d/%0d want 0/0", in_count, out_count); else n_pass++;
    endtask

    task automatic test_timeout_edge();
        int i_cyc;
        dp_auto = 1'b0; out_ready = 1'b0;
        i_cyc = -1;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            force_y = 1'b0;
            in_valid = (k == 0);
            in_data = 32'h400;
            if (dp_x_valid && i_cyc < 0) i_cyc = cyc;
            if (i_cyc >= 0 && cyc == i_cyc + 64) begin
                force_y = 1'b1; force_data = 32'hABC;
            end
        end
        n_checks++; if (timeout_err !== 1'b0) $display("FAIL edge_timeout_err: got %b want 0", timeout_err); else n_pass++;
        n_checks++; if (out_count !== 4'd1) $display("FAIL edge_out_count: got %0d want 1", out_count); else n_pass++;
        n_checks++; if (out_data !== 32'hABC) $display("FAIL edge_out_data: got %h want abc", out_data); else n_pass++;
        force_y = 1'b1; force_data = 32'hDEAD;
        @(negedge clk); force_y = 1'b0;
        @(negedge clk);
        n_checks++; if (out_count !== 4'd1) $display("FAIL stray_out_count: got %0d want 1", out_count); else n_pass++;
        n_checks++; if (out_data !== 32'hABC) $display("FAIL stray_out_data: got %h want abc", out_data); else n_pass++;
        out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
        n_checks++; if (out_count !== 4'd0) $display("FAIL edge_drain: got %0d want 0", out_count); else n_pass++;
    endtask

    task automatic test_flush_wait();
        int base, i_cyc;
        dp_auto = 1'b0; out_ready = 1'b0;
        base = x_cyc.size(); i_cyc = -1;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            flush = 1'b0; force_y = 1'b0;
            in_valid = (k == 0);
            in_data = 32'h500;
            if (dp_x_valid && i_cyc < 0) i_cyc = cyc;
            if (i_cyc >= 0 && cyc == i_cyc + 3) flush = 1'b1;
            if (i_cyc >= 0 && cyc == i_cyc + 4) begin
                force_y = 1'b1; force_data = 32'h555;
            end
        end
        n_checks++; if (out_count !== 4'd0) $display("FAIL fw_out_count: got %0d want 0", out_count); else n_pass++;
        n_checks++; if (busy !== 1'b0 || timeout_err !== 1'b0) $display("FAIL fw_idle: got busy=%b err=%b want 0/0", busy, timeout_err); else n_pass++;
        n_checks++; if (x_cyc.size() - base !== 1) $display("FAIL fw_issue_count: got %0d want 1", x_cyc.size() - base); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; dp_ready = 1'b0; dp_auto = 1'b0; force_y = 1'b0; force_data = '0;
        test_reset();
        test_stream();
        test_in_backpressure();
        test_out_full();
        test_timeout();
        test_timeout_edge();
        test_flush_wait();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
